// File: rtl/reg_file_pkg.sv
// Purpose: shared widths and types for the ID-stage register file.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package reg_file_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_read_port.sv
// Purpose: one read port of the register file; priority mux with WB bypass.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output is valid every cycle.
//
// Ports:
//   rst                               - register file reset, forces output to 0
//   en, addr                          - read enable and register index
//   stored_data                       - current storage contents at addr (0 for $0)
//   write_en, write_addr, write_data  - WB write port, used for same-cycle bypass
//   read_data                         - operand returned to ID
module reg_read_port
    import reg_file_pkg::*;
(
    input  logic      rst,
    input  logic      en,
    input  reg_addr_t addr,
    input  reg_data_t stored_data,
    input  logic      write_en,
    input  reg_addr_t write_addr,
    input  reg_data_t write_data,
    output reg_data_t read_data
);

    always_comb begin
        read_data = '0;
        if (rst || !en || (addr == '0)) begin
            read_data = '0;
        end else if (write_en && (write_addr == addr)) begin
            // WB result forwarded so ID never sees a stale value.
            read_data = write_data;
        end else begin
            read_data = stored_data;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Purpose: 32x32 MIPS register file, two read ports, one write port, $0 hardwired to 0.
// Latency: reads 0 cycles (with WB bypass); writes land in storage on the next rising edge.
// Backpressure: none; every port is valid every cycle.
//
// Ports:
//   clk, rst                            - clock, async active-high reset
//   read_en_1/2, read_addr_1/2          - read port enables and indices (rs, rt)
//   read_data_1/2                       - combinational operand data
//   write_en, write_addr, write_data    - WB write port
module reg_file
    import reg_file_pkg::*;
#(
    parameter int REG_COUNT  = reg_file_pkg::REG_COUNT,
    parameter int DATA_WIDTH = REG_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_en_1,
    input  logic [REG_ADDR_W-1:0] read_addr_1,
    output logic [DATA_WIDTH-1:0] read_data_1,
    input  logic                  read_en_2,
    input  logic [REG_ADDR_W-1:0] read_addr_2,
    output logic [DATA_WIDTH-1:0] read_data_2,
    input  logic                  write_en,
    input  logic [REG_ADDR_W-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data
);

    // Registers 1..REG_COUNT-1 only; index 0 has no storage.
    reg_data_t mem [1:REG_COUNT-1];

    reg_data_t stored_1;
    reg_data_t stored_2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                mem[i] <= '0;
            end
        end else if (write_en && (write_addr != '0)) begin
            mem[write_addr] <= write_data;
        end
    end

    // Guard index 0 so the array is never addressed out of range.
    always_comb begin
        stored_1 = '0;
        if (read_addr_1 != '0) begin
            stored_1 = mem[read_addr_1];
        end
    end

    always_comb begin
        stored_2 = '0;
        if (read_addr_2 != '0) begin
            stored_2 = mem[read_addr_2];
        end
    end

    reg_read_port u_read_port_1 (
        .rst         (rst),
        .en          (read_en_1),
        .addr        (read_addr_1),
        .stored_data (stored_1),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .read_data   (read_data_1)
    );

    reg_read_port u_read_port_2 (
        .rst         (rst),
        .en          (read_en_2),
        .addr        (read_addr_2),
        .stored_data (stored_2),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .read_data   (read_data_2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Purpose: directed self-checking bench for reg_file.
// Latency: n/a.
// Backpressure: n/a.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        read_en_1;
    logic [4:0]  read_addr_1;
    logic [31:0] read_data_1;
    logic        read_en_2;
    logic [4:0]  read_addr_2;
    logic [31:0] read_data_2;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    int checks   = 0;
    int failures = 0;

    reg_file dut (
        .clk         (clk),
        .rst         (rst),
        .read_en_1   (read_en_1),
        .read_addr_1 (read_addr_1),
        .read_data_1 (read_data_1),
        .read_en_2   (read_en_2),
        .read_addr_2 (read_addr_2),
        .read_data_2 (read_data_2),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .write_data  (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        write_en   = 1'b1;
        write_addr = a;
        write_data = d;
        tick();
        write_en   = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        read_en_1   = 1'b1;
        read_addr_1 = a1;
        read_en_2   = 1'b1;
        read_addr_2 = a2;
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        read_en_1   = 1'b1;
        read_addr_1 = 5'd5;
        read_en_2   = 1'b1;
        read_addr_2 = 5'd7;
        write_en    = 1'b1;
        write_addr  = 5'd5;
        write_data  = 32'h1111_1111;
        #1;
        chk("reset_rd1", read_data_1, 32'h0);
        chk("reset_rd2", read_data_2, 32'h0);
        // Write presented across an edge during reset must be lost.
        tick();
        write_en = 1'b0;
        rst      = 1'b0;
        rd(5'd5, 5'd5);
        chk("reset_write_lost", read_data_1, 32'h0);

        // Basic write then read on both ports.
        do_write(5'd7, 32'h1234_5678);
        rd(5'd7, 5'd7);
        chk("basic_rd1", read_data_1, 32'h1234_5678);
        chk("basic_rd2", read_data_2, 32'h1234_5678);

        // Reset mid-cycle clears contents immediately.
        do_write(5'd5, 32'hDEAD_BEEF);
        rd(5'd5, 5'd7);
        chk("pre_rst_r5", read_data_1, 32'hDEAD_BEEF);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_rd1", read_data_1, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_r5", read_data_1, 32'h0);
        chk("post_rst_r7", read_data_2, 32'h0);
        tick();

        // Bypass on both ports.
        do_write(5'd9, 32'h0000_0001);
        write_en   = 1'b1;
        write_addr = 5'd9;
        write_data = 32'hCAFE_F00D;
        rd(5'd9, 5'd9);
        chk("bypass_rd1", read_data_1, 32'hCAFE_F00D);
        chk("bypass_rd2", read_data_2, 32'hCAFE_F00D);
        tick();
        write_en = 1'b0;
        #1;
        chk("bypass_stored1", read_data_1, 32'hCAFE_F00D);
        chk("bypass_stored2", read_data_2, 32'hCAFE_F00D);

        // $0 immutability.
        write_en   = 1'b1;
        write_addr = 5'd0;
        write_data = 32'hFFFF_FFFF;
        rd(5'd0, 5'd0);
        chk("r0_same_cycle1", read_data_1, 32'h0);
        chk("r0_same_cycle2", read_data_2, 32'h0);
        tick();
        write_en = 1'b0;
        #1;
        chk("r0_after1", read_data_1, 32'h0);
        tick();
        chk("r0_later2", read_data_2, 32'h0);

        // Enable gating and disabled-write non-bypass.
        do_write(5'd3, 32'hA5A5_A5A5);
        rd(5'd3, 5'd3);
        read_en_1 = 1'b0;
        #1;
        chk("gate_rd1", read_data_1, 32'h0);
        chk("gate_rd2_en", read_data_2, 32'hA5A5_A5A5);
        write_en   = 1'b1;
        write_addr = 5'd3;
        write_data = 32'h0000_0011;
        read_en_1  = 1'b1;
        read_en_2  = 1'b0;
        #1;
        chk("gate_rd2_bypass", read_data_2, 32'h0);
        chk("bypass_rd1_r3", read_data_1, 32'h0000_0011);
        write_en   = 1'b0;
        write_data = 32'h0000_0077;
        #1;
        chk("no_bypass_wen0", read_data_1, 32'hA5A5_A5A5);
        tick();
        chk("no_write_wen0", read_data_1, 32'hA5A5_A5A5);

        // Sweep: r_i = i * 0x01010101, read pairs (r_i, r_32-i).
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 32'(i) * 32'h0101_0101);
        end
        for (int i = 1; i < 32; i++) begin
            rd(5'(i), 5'(32 - i));
            chk($sformatf("sweep_p1_r%0d", i), read_data_1, 32'(i) * 32'h0101_0101);
            chk($sformatf("sweep_p2_r%0d", 32 - i), read_data_2, 32'(32 - i) * 32'h0101_0101);
        end
        rd(5'd0, 5'd31);
        chk("sweep_r0", read_data_1, 32'h0);
        chk("sweep_r31", read_data_2, 32'h1F1F_1F1F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
